bit_serial_subtractor: RTL and testbench
========================================

Name: bit_serial_subtractor

Overview:
Computes D = A - B one bit per clock, LSB first. It is the inverse-operation companion to the bit-serial adder in the FPU datapath and is used wherever area matters more than latency, such as exponent difference and mantissa alignment. It uses the same start/done handshake as the adder. It also produces borrow, signed-overflow, zero and negative flags for downstream compare logic.

Parameters:
N, 8, operand and result width in bits; legal range N >= 2.

Ports:
CLOCK_50  input  1  system clock; all logic on its rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request a new operation; sampled only when not busy
A  input  N  minuend; captured on an accepted start
B  input  N  subtrahend; captured on an accepted start
D  output  N  difference A - B, modulo 2^N
Bout  output  1  final borrow; 1 iff A < B unsigned
ovf  output  1  signed (two's complement) overflow
zero  output  1  1 iff D == 0
neg  output  1  D[N-1]
busy  output  1  operation in progress
done  output  1  result valid; held high until the next accepted start or reset

Behaviour:
- One clock domain. Reset is synchronous and active-low: when rst_n = 0 at a CLOCK_50 rising edge, all outputs and state are cleared (D = 0, Bout = ovf = zero = neg = busy = done = 0, FSM = IDLE).
- Reset mid-operation aborts the operation. No partial result and no done pulse are produced.
- FSM states: IDLE, RUN, FIN.
  - IDLE/FIN with start = 1: accept the request.
    - Latch A and B into internal registers.
    - Clear D, all flags and done; set bit counter = 0, borrow = 0, busy = 1.
    - Go to RUN.
  - RUN: each cycle, the full-subtractor cell takes Ai[cnt], Bi[cnt] and the borrow register.
    - D[cnt] <= diff; borrow <= bout; cnt <= cnt + 1.
    - After bit N-1 is written, go to FIN.
  - FIN (entry cycle): the registered outputs are updated at the end of this cycle.
    - Bout <= borrow.
    - neg <= D[N-1].
    - zero <= (D == 0).
    - ovf <= (Ai[N-1] != Bi[N-1]) && (D[N-1] != Ai[N-1]).
    - done <= 1; busy <= 0.
    - The FSM stays in FIN (idle-with-result) until the next start.
- Latency:
  - start sampled at edge k.
  - Result bits are written at edges k+1 .. k+N.
  - done = 1 and all flags are valid after edge k+N+1.
  - Throughput is one operation per N+1 cycles minimum.
- start while busy = 1 is ignored. It is not queued, and operands are not re-latched.
- start in the same cycle that done is high is accepted. done drops at the next edge.
- A and B may change freely after acceptance, because the internal copies are used.
- The counter is $clog2(N)+1 bits wide and never wraps within an operation.
- D is visible while partially built during RUN. Consumers must qualify it with done.

Decomposition:
- Shared FPU package holds:
  - the FSM state encoding localparams (ST_IDLE, ST_RUN, ST_FIN);
  - the default width constant shared with the adder.
- One natural sub-module: full_subtractor (A, B, Bin -> Diff, Bout), purely combinational.
  - Diff = A ^ B ^ Bin.
  - Bout = (~A & B) | (~(A ^ B) & Bin).
  - It mirrors the existing full_adder cell.

Test Plan:
1. N=8, A=0x50, B=0x20, start pulse -> after N+1 = 9 cycles: done=1, D=0x30, Bout=0, ovf=0, zero=0, neg=0; busy high for exactly 8 cycles.
2. A=0x20, B=0x50 -> D=0xD0, Bout=1, neg=1, ovf=0.
3. A=0x80, B=0x01 -> D=0x7F, ovf=1, Bout=0, neg=0. Also A=0x7F, B=0xFF -> D=0x80, ovf=1, Bout=1.
4. A=B=0x37 -> D=0x00, zero=1, Bout=0. Then exercise start handling:
   - assert start with A=0x01, B=0x02 while done=1 -> accepted; done drops next edge; result D=0xFF, Bout=1.
   - re-assert start mid-RUN with different operands -> ignored; the original result is unchanged.
5. Start A=0xAA, B=0x55, then pull rst_n low at cycle 4 for one edge -> all outputs 0, busy=0, no done. A subsequent start with A=0xAA, B=0x55 yields D=0x55, done after 9 cycles.
6. Randomised 1000 operations at N=8 and N=16 against a reference model; change A and B every cycle during RUN -> results must match the operands latched at accept.

Source files
------------

// File: rtl/bit_serial_subtractor_pkg.sv
// ----------------------------------------------------------------------------
// bit_serial_subtractor_pkg
//
// Purpose : Shared FPU serial-datapath definitions. Holds the sequencer state
//           encoding used by the bit-serial subtractor (and mirrored by the
//           bit-serial adder) plus the default operand width shared by both.
//
// Contents:
//   DEFAULT_WIDTH  default operand/result width for the serial units
//   state_t        2-bit sequencer state type
//   ST_IDLE        waiting for the first start after reset
//   ST_RUN         one result bit produced per clock, LSB first
//   ST_FIN         flags latched, result held until the next start
// ----------------------------------------------------------------------------
package bit_serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_FIN  = 2'd2;

endpackage

// File: rtl/bit_serial_subtractor_full_subtractor.sv
// ----------------------------------------------------------------------------
// full_subtractor
//
// Purpose : One-bit full subtractor cell, the subtracting twin of full_adder.
//           Computes a - b - bin and the borrow into the next bit position.
//           Purely combinational.
//
// Ports:
//   a     input  1  minuend bit
//   b     input  1  subtrahend bit
//   bin   input  1  borrow in from the less significant bit
//   diff  output 1  difference bit
//   bout  output 1  borrow out to the more significant bit
// ----------------------------------------------------------------------------
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;

    // Borrow when b exceeds a outright, or when they tie and a borrow
    // is already pending from below.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/bit_serial_subtractor.sv
// ----------------------------------------------------------------------------
// bit_serial_subtractor
//
// Purpose : Computes D = A - B one bit per clock, LSB first, for area-critical
//           FPU paths (exponent difference, mantissa alignment). Shares the
//           start/done handshake of the bit-serial adder and additionally
//           produces borrow, signed-overflow, zero and negative flags.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | no result yet since reset; waiting for start
//   ST_RUN  | writing D[cnt] from the cell each clock, cnt = 0 .. N-1
//   ST_FIN  | first cycle latches flags/done; then holds result until start
//
// Ports:
//   CLOCK_50  input  1  system clock, rising edge
//   rst_n     input  1  synchronous active-low reset
//   start     input  1  request a new operation; ignored while busy
//   A         input  N  minuend, captured on an accepted start
//   B         input  N  subtrahend, captured on an accepted start
//   D         output N  A - B modulo 2^N (partial while busy)
//   Bout      output 1  final borrow, 1 iff A < B unsigned
//   ovf       output 1  two's complement overflow
//   zero      output 1  D == 0
//   neg       output 1  D[N-1]
//   busy      output 1  operation in progress
//   done      output 1  result valid; held until next accepted start
//
// Latency: start sampled at edge k, bits written at edges k+1..k+N, flags
// and done valid after edge k+N+1.
// ----------------------------------------------------------------------------
module bit_serial_subtractor
    import bit_serial_subtractor_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH
) (
    input  logic         CLOCK_50,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] D,
    output logic         Bout,
    output logic         ovf,
    output logic         zero,
    output logic         neg,
    output logic         busy,
    output logic         done
);

    // One spare counter bit so the count can never wrap inside an operation.
    localparam int              CW   = $clog2(N) + 1;
    localparam int              IW   = $clog2(N);
    localparam logic [CW-1:0]   LAST = CW'(N - 1);

    state_t          state;
    state_t          state_nxt;

    logic [N-1:0]    a_q;
    logic [N-1:0]    b_q;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   idx;
    logic            borrow;

    logic            cell_diff;
    logic            cell_bout;

    logic            accept;
    logic            step;
    logic            finish;

    assign idx = cnt[IW-1:0];

    full_subtractor u_cell (
        .a    (a_q[idx]),
        .b    (b_q[idx]),
        .bin  (borrow),
        .diff (cell_diff),
        .bout (cell_bout)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt == LAST) begin
                    state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                if (start) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    // A start arriving in FIN wins over the flag update: the new operation
    // clears everything anyway. Staying in FIN re-evaluates the flags from
    // unchanged registers, so the held result is stable.
    always_comb begin
        accept = 1'b0;
        step   = 1'b0;
        finish = 1'b0;
        case (state)
            ST_IDLE: begin
                accept = start;
            end
            ST_RUN: begin
                step = 1'b1;
            end
            ST_FIN: begin
                accept = start;
                finish = ~start;
            end
            default: begin
                accept = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            D      <= '0;
            Bout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
            neg    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (accept) begin
            a_q    <= A;
            b_q    <= B;
            cnt    <= '0;
            borrow <= 1'b0;
            D      <= '0;
            Bout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
            neg    <= 1'b0;
            busy   <= 1'b1;
            done   <= 1'b0;
        end else if (step) begin
            D[idx] <= cell_diff;
            borrow <= cell_bout;
            cnt    <= cnt + CW'(1);
        end else if (finish) begin
            Bout <= borrow;
            neg  <= D[N-1];
            zero <= (D == '0);
            // Overflow only possible when operand signs differ, and shows up
            // as the result sign disagreeing with the minuend sign.
            ovf  <= (a_q[N-1] != b_q[N-1]) && (D[N-1] != a_q[N-1]);
            busy <= 1'b0;
            done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bit_serial_subtractor.sv
module tb_bit_serial_subtractor;

    logic CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    logic        rst_n;

    logic        start8;
    logic [7:0]  a8, b8, d8;
    logic        bout8, ovf8, zero8, neg8, busy8, done8;

    logic        start16;
    logic [15:0] a16, b16, d16;
    logic        bout16, ovf16, zero16, neg16, busy16, done16;

    bit_serial_subtractor #(.N(8)) dut8 (
        .CLOCK_50 (CLOCK_50),
        .rst_n    (rst_n),
        .start    (start8),
        .A        (a8),
        .B        (b8),
        .D        (d8),
        .Bout     (bout8),
        .ovf      (ovf8),
        .zero     (zero8),
        .neg      (neg8),
        .busy     (busy8),
        .done     (done8)
    );

    bit_serial_subtractor #(.N(16)) dut16 (
        .CLOCK_50 (CLOCK_50),
        .rst_n    (rst_n),
        .start    (start16),
        .A        (a16),
        .B        (b16),
        .D        (d16),
        .Bout     (bout16),
        .ovf      (ovf16),
        .zero     (zero16),
        .neg      (neg16),
        .busy     (busy16),
        .done     (done16)
    );

    typedef struct packed {
        logic [15:0] d;
        logic        bout;
        logic        ovf;
        logic        zero;
        logic        neg;
    } exp_t;

    exp_t sb8[$];
    exp_t sb16[$];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model using signed/unsigned integer arithmetic.
    function automatic exp_t model(input int n, input logic [15:0] a, input logic [15:0] b);
        longint m, half, ua, ub, sa, sb, sd;
        exp_t   e;
        m    = (longint'(1) << n) - 1;
        half = longint'(1) << (n - 1);
        ua   = longint'(a) & m;
        ub   = longint'(b) & m;
        sa   = (ua >= half) ? ua - (m + 1) : ua;
        sb   = (ub >= half) ? ub - (m + 1) : ub;
        sd   = sa - sb;
        e.d    = 16'((ua - ub) & m);
        e.bout = (ua < ub);
        e.ovf  = (sd >= half) || (sd < -half);
        e.zero = (e.d == 16'h0000);
        e.neg  = e.d[n-1];
        return e;
    endfunction

    function automatic exp_t mk(input logic [15:0] d, input logic bo, input logic ov,
                                input logic z, input logic ng);
        exp_t e;
        e.d = d; e.bout = bo; e.ovf = ov; e.zero = z; e.neg = ng;
        return e;
    endfunction

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input exp_t e,
                       input bit scramble, input bit mid_start);
        int   t;
        int   nb;
        exp_t x;
        @(negedge CLOCK_50);
        a8 = a; b8 = b; start8 = 1'b1;
        sb8.push_back(e);
        @(negedge CLOCK_50);
        start8 = 1'b0;
        chk("accept_busy8", busy8, 1);
        chk("accept_done8", done8, 0);
        t = 0; nb = 0;
        while (done8 !== 1'b1 && t < 40) begin
            if (scramble) begin
                a8 = 8'($urandom); b8 = 8'($urandom);
            end
            if (mid_start && t == 3) begin
                a8 = 8'hFF; b8 = 8'h01; start8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            @(negedge CLOCK_50);
            t++;
            if (busy8 === 1'b1 && done8 !== 1'b1) nb++;
        end
        start8 = 1'b0;
        chk("latency8", t, 9);
        chk("busy_cycles8", nb, 8);
        chk("busy_clear8", busy8, 0);
        x = sb8.pop_front();
        chk("d8", d8, x.d[7:0]);
        chk("bout8", bout8, x.bout);
        chk("ovf8", ovf8, x.ovf);
        chk("zero8", zero8, x.zero);
        chk("neg8", neg8, x.neg);
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b);
        int   t;
        exp_t x;
        @(negedge CLOCK_50);
        a16 = a; b16 = b; start16 = 1'b1;
        sb16.push_back(model(16, a, b));
        @(negedge CLOCK_50);
        start16 = 1'b0;
        t = 0;
        while (done16 !== 1'b1 && t < 60) begin
            a16 = 16'($urandom); b16 = 16'($urandom);
            @(negedge CLOCK_50);
            t++;
        end
        chk("latency16", t, 17);
        chk("busy_clear16", busy16, 0);
        x = sb16.pop_front();
        chk("d16", d16, x.d);
        chk("bout16", bout16, x.bout);
        chk("ovf16", ovf16, x.ovf);
        chk("zero16", zero16, x.zero);
        chk("neg16", neg16, x.neg);
    endtask

    initial begin
        int   nd;
        logic [7:0]  ra, rb;
        logic [15:0] wa, wb;

        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start16 = 1'b0; a16 = '0; b16 = '0;
        repeat (3) @(negedge CLOCK_50);
        chk("rst_d8", d8, 0);
        chk("rst_flags8", {bout8, ovf8, zero8, neg8, busy8, done8}, 0);
        chk("rst_d16", d16, 0);
        chk("rst_flags16", {bout16, ovf16, zero16, neg16, busy16, done16}, 0);
        rst_n = 1'b1;

        // Directed cases with hand-derived expectations.
        op8(8'h50, 8'h20, mk(16'h0030, 0, 0, 0, 0), 1'b0, 1'b0);
        op8(8'h20, 8'h50, mk(16'h00D0, 1, 0, 0, 1), 1'b0, 1'b0);
        op8(8'h80, 8'h01, mk(16'h007F, 0, 1, 0, 0), 1'b0, 1'b0);
        op8(8'h7F, 8'hFF, mk(16'h0080, 1, 1, 0, 1), 1'b0, 1'b0);
        op8(8'h37, 8'h37, mk(16'h0000, 0, 0, 1, 0), 1'b0, 1'b0);
        // Started while done is high: accepted, done drops after one edge.
        op8(8'h01, 8'h02, mk(16'h00FF, 1, 0, 0, 1), 1'b0, 1'b0);
        // A start mid-RUN with other operands must be ignored.
        op8(8'h10, 8'h03, mk(16'h000D, 0, 0, 0, 0), 1'b0, 1'b1);

        // Abort with reset partway through an operation.
        @(negedge CLOCK_50);
        a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
        @(negedge CLOCK_50);
        start8 = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        rst_n = 1'b0;
        @(negedge CLOCK_50);
        rst_n = 1'b1;
        chk("abort_d8", d8, 0);
        chk("abort_flags8", {bout8, ovf8, zero8, neg8, busy8, done8}, 0);
        nd = 0;
        repeat (12) begin
            @(negedge CLOCK_50);
            if (done8 === 1'b1 || busy8 === 1'b1) nd++;
        end
        chk("abort_no_done8", nd, 0);
        op8(8'hAA, 8'h55, mk(16'h0055, 0, 1, 0, 0), 1'b0, 1'b0);

        // Randomised, operands scrambled during RUN.
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            op8(ra, rb, model(8, {8'h00, ra}, {8'h00, rb}), 1'b1, 1'b0);
        end
        for (int i = 0; i < 1000; i++) begin
            wa = 16'($urandom); wb = 16'($urandom);
            op16(wa, wb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
